// File: rtl/mac_pkg.sv
// Shared types and constants for the signed multiply-accumulate sequencer.
// Holds the FSM state encoding, default widths and the product sign-extension helper.
// Combinational only; no latency or flow control of its own.
package mac_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 20;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widen a full-precision signed product to the accumulator width.
  function automatic logic [DEF_ACC_W-1:0] sext_prod(input logic [2*DEF_DATA_W-1:0] p);
    return {{(DEF_ACC_W - 2*DEF_DATA_W){p[2*DEF_DATA_W-1]}}, p};
  endfunction

endpackage

// File: rtl/mac_datapath.sv
// Operand register, registered signed product and wrapping accumulator with sticky overflow.
// Latency: accept at edge k -> product at k+1 -> accumulator at k+2; one pair per cycle.
// No backpressure: every accepted pair flows through; the sequencer gates acceptance.
module mac_datapath import mac_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_fire,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              drain_busy
);

  logic [DATA_W-1:0]          a_q, a_d, b_q, b_d;
  logic                       op_vld_q, op_vld_d;
  logic [2*DATA_W-1:0]        prod_q, prod_d;
  logic                       prod_vld_q, prod_vld_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic                       ovf_q, ovf_d;
  logic signed [2*DATA_W-1:0] a_ext, b_ext;
  logic [ACC_W-1:0]           addend, sum;

  // Next-state for operand capture, product stage and accumulate stage.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    op_vld_d   = in_fire;
    prod_d     = prod_q;
    prod_vld_d = op_vld_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    a_ext      = {{DATA_W{a_q[DATA_W-1]}}, a_q};
    b_ext      = {{DATA_W{b_q[DATA_W-1]}}, b_q};
    addend     = sext_prod(prod_q);
    sum        = acc_q + addend;
    if (in_fire) begin
      a_d = a;
      b_d = b;
    end
    if (op_vld_q) begin
      prod_d = a_ext * b_ext;
    end
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (prod_vld_q) begin
      acc_d = sum;
      // Same-sign addends whose sum flips sign have wrapped.
      if ((acc_q[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1])) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_vld_q   <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      op_vld_q   <= op_vld_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

  assign acc_out  = acc_q;
  assign overflow = ovf_q;
  // A pending product lands on the same edge the sequencer leaves DRAIN,
  // so only the operand stage has to be empty before moving on.
  assign drain_busy = op_vld_q;

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one multiply-accumulate job: latch term count, accept pairs, present the sum.
// Latency: result valid in the cycle after edge k+2 of the final accept (zero terms: next cycle).
// in_ready only while terms remain in RUN; result held in DONE until out_ready.
module mac_sequencer import mac_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              overflow
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, nterms_q, nterms_d;
  logic             in_fire, clr, drain_busy;

  // FSM next-state, term counting and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nterms_d  = nterms_q;
    clr       = 1'b0;
    in_ready  = 1'b0;
    in_fire   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr      = 1'b1;
          nterms_d = num_terms;
          cnt_d    = '0;
          state_d  = (num_terms == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = (cnt_q < nterms_q);
        in_fire  = in_valid && in_ready;
        if (in_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == nterms_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!drain_busy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and latched term count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      nterms_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nterms_q <= nterms_d;
    end
  end

  assign busy = (state_q != IDLE);

  mac_datapath #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_fire    (in_fire),
    .a          (a),
    .b          (b),
    .acc_out    (acc_out),
    .overflow   (overflow),
    .drain_busy (drain_busy)
  );

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: expected sums queued at start, checked on result handshake.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_terms = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [19:0] acc_out;
  logic        busy;
  logic        overflow;

  typedef struct packed {
    logic [19:0] acc;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare each presented result against the oldest expected job.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL result_unexpected: got acc=%0h with no job outstanding", acc_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_acc", 32'(acc_out), 32'(e.acc));
        check("result_ovf", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  task automatic start_job(input int n, input logic [19:0] exp_acc, input logic exp_ovf, input bit expect_result);
    if (expect_result) sb.push_back('{acc: exp_acc, ovf: exp_ovf});
    start     = 1'b1;
    num_terms = 8'(n);
    @(posedge clk);
    #1;
    start     = 1'b0;
    num_terms = 8'hAA;
  endtask

  task automatic send(input int av, input int bv);
    int n;
    a        = av[7:0];
    b        = bv[7:0];
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 8'h5A;
    b        = 8'hA5;
  endtask

  task automatic wait_out(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({"wait_", nm}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_acc", 32'(acc_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic job: 12 - 10 - 7 = -5
    start_job(3, 20'hFFFFB, 1'b0, 1'b1);
    check("run_busy", 32'(busy), 32'd1);
    send(3, 4);
    send(-2, 5);
    send(7, -1);
    check("lat_k", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_k1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_k2", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_acc_hold", 32'(acc_out), 32'h000FFFFB);

    // Zero terms: straight to DONE with a cleared accumulator
    start_job(0, 20'h0, 1'b0, 1'b1);
    check("zero_out_valid", 32'(out_valid), 32'd1);
    check("zero_in_ready", 32'(in_ready), 32'd0);
    check("zero_acc", 32'(acc_out), 32'd0);
    @(posedge clk); #1;
    check("zero_idle", 32'(busy), 32'd0);

    // Bubbles and result backpressure: 16384 + 16129
    out_ready = 1'b0;
    start_job(2, 20'd32513, 1'b0, 1'b1);
    send(-128, -128);
    repeat (2) @(posedge clk);
    #1;
    check("bubble_in_ready", 32'(in_ready), 32'd1);
    send(127, 127);
    wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_acc", 32'(acc_out), 32'd32513);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Overflow: 40 * 16384 = 655360 wraps to -393216 (0xA0000)
    start_job(40, 20'hA0000, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) send(-128, -128);
    wait_out("ovf");
    check("ovf_flag", 32'(overflow), 32'd1);
    @(posedge clk); #1;

    // Start ignored in RUN, in DONE and on the handshake edge: 2 + 12 = 14
    out_ready = 1'b0;
    start_job(2, 20'd14, 1'b0, 1'b1);
    send(1, 2);
    start = 1'b1; num_terms = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_run_busy", 32'(busy), 32'd1);
    check("ign_run_in_ready", 32'(in_ready), 32'd1);
    send(3, 4);
    wait_out("ign");
    start = 1'b1; num_terms = 8'd5;
    @(posedge clk); #1;
    check("ign_done_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_hs_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("ign_hs_still_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN after 2 of 4 pairs
    start_job(4, 20'h0, 1'b0, 1'b0);
    send(2, 3);
    send(4, 5);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_acc", 32'(acc_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fresh job after reset
    start_job(1, 20'd30, 1'b0, 1'b1);
    send(5, 6);
    wait_out("post_rst");
    @(posedge clk); #1;

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
